// File: rtl/it_block_ctrl.sv
// IT-block sequencer: holds ITSTATE, advances it per instruction leaving decode, evaluates conditions.
// Optional macro IT_BLOCK_FAULT_EN enables the sticky illegal-IT fault flag.
module it_block_ctrl #(
  parameter int unsigned ITW                = 8,
  parameter bit          RESTORE_EN_DEFAULT = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           it_load,
  input  logic [3:0]     it_firstcond,
  input  logic [3:0]     it_mask,
  input  logic           adv,
  input  logic           stall,
  input  logic           flush,
  input  logic           restore_valid,
  input  logic [ITW-1:0] restore_itstate,
  input  logic [3:0]     instr_cond,
  input  logic           N,
  input  logic           Z,
  input  logic           C,
  input  logic           V,
  output logic [ITW-1:0] itstate,
  output logic           in_it,
  output logic           it_last,
  output logic [2:0]     it_remaining,
  output logic [3:0]     cond_out,
  output logic           exec_pass,
  output logic           it_fault
);

  logic [ITW-1:0] itstate_q, itstate_d;
  logic           restore_en;
  logic           load_req;

  assign restore_en = RESTORE_EN_DEFAULT && restore_valid;
  // A zero mask encodes a hint instruction, not an IT block.
  assign load_req   = it_load && (it_mask != 4'b0000);

`ifdef IT_BLOCK_FAULT_EN
  logic fault_q, fault_d;
  logic load_illegal;

  assign load_illegal = in_it || (it_firstcond == 4'b1111);
`endif

  always_comb begin
    itstate_d = itstate_q;
`ifdef IT_BLOCK_FAULT_EN
    fault_d   = fault_q;
`endif
    if (restore_en) begin
      itstate_d = restore_itstate;
`ifdef IT_BLOCK_FAULT_EN
      fault_d   = 1'b0;
`endif
    end else if (flush) begin
      itstate_d = '0;
    end else if (stall) begin
      itstate_d = itstate_q;
    end else if (load_req) begin
`ifdef IT_BLOCK_FAULT_EN
      if (load_illegal) begin
        fault_d = 1'b1;
      end else begin
        itstate_d = {it_firstcond, it_mask};
      end
`else
      itstate_d = {it_firstcond, it_mask};
`endif
    end else if (adv && in_it) begin
      if (itstate_q[2:0] == 3'b000) begin
        itstate_d = '0;
      end else begin
        // cond[3:1] is fixed for the block; cond[0] and mask shift together.
        itstate_d = {itstate_q[7:5], itstate_q[3:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      itstate_q <= '0;
`ifdef IT_BLOCK_FAULT_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      itstate_q <= itstate_d;
`ifdef IT_BLOCK_FAULT_EN
      fault_q   <= fault_d;
`endif
    end
  end

`ifdef IT_BLOCK_FAULT_EN
  assign it_fault = fault_q;
`else
  assign it_fault = 1'b0;
`endif

  assign itstate  = itstate_q;
  assign in_it    = (itstate_q[3:0] != 4'b0000);
  assign it_last  = (itstate_q[3:0] == 4'b1000);
  assign cond_out = in_it ? itstate_q[7:4] : instr_cond;

  always_comb begin
    it_remaining = 3'd0;
    casez (itstate_q[3:0])
      4'b???1: it_remaining = 3'd4;
      4'b??10: it_remaining = 3'd3;
      4'b?100: it_remaining = 3'd2;
      4'b1000: it_remaining = 3'd1;
      default: it_remaining = 3'd0;
    endcase
  end

  // Condition evaluator; 1111 (NV) never passes.
  always_comb begin
    exec_pass = 1'b0;
    unique case (cond_out)
      4'b0000: exec_pass = Z;
      4'b0001: exec_pass = !Z;
      4'b0010: exec_pass = C;
      4'b0011: exec_pass = !C;
      4'b0100: exec_pass = N;
      4'b0101: exec_pass = !N;
      4'b0110: exec_pass = V;
      4'b0111: exec_pass = !V;
      4'b1000: exec_pass = C && !Z;
      4'b1001: exec_pass = !C || Z;
      4'b1010: exec_pass = (N == V);
      4'b1011: exec_pass = (N != V);
      4'b1100: exec_pass = !Z && (N == V);
      4'b1101: exec_pass = Z || (N != V);
      4'b1110: exec_pass = 1'b1;
      4'b1111: exec_pass = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_it_block_ctrl.sv
// Scoreboard bench for it_block_ctrl: stimulus queues expected outputs, monitor compares at negedge.
module tb_it_block_ctrl;

`ifdef IT_BLOCK_FAULT_EN
  localparam bit FaultEn = 1'b1;
`else
  localparam bit FaultEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       it_load = 1'b0;
  logic [3:0] it_firstcond = '0;
  logic [3:0] it_mask = '0;
  logic       adv = 1'b0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic       restore_valid = 1'b0;
  logic [7:0] restore_itstate = '0;
  logic [3:0] instr_cond = 4'b1110;
  logic       N = 1'b0, Z = 1'b0, C = 1'b0, V = 1'b0;
  logic [7:0] itstate;
  logic       in_it, it_last, exec_pass, it_fault;
  logic [2:0] it_remaining;
  logic [3:0] cond_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] it;
    logic [2:0] rem;
    logic [3:0] cond;
    logic       pass;
    logic       fault;
  } exp_t;

  exp_t q[$];

  it_block_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .it_load         (it_load),
    .it_firstcond    (it_firstcond),
    .it_mask         (it_mask),
    .adv             (adv),
    .stall           (stall),
    .flush           (flush),
    .restore_valid   (restore_valid),
    .restore_itstate (restore_itstate),
    .instr_cond      (instr_cond),
    .N               (N),
    .Z               (Z),
    .C               (C),
    .V               (V),
    .itstate         (itstate),
    .in_it           (in_it),
    .it_last         (it_last),
    .it_remaining    (it_remaining),
    .cond_out        (cond_out),
    .exec_pass       (exec_pass),
    .it_fault        (it_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, string field, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s actual=%0h expected=%0h", nm, field, act, exp);
    end
  endtask

  // Monitor: compares one queued expectation per falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, "itstate", int'(itstate), int'(e.it));
        chk(e.name, "in_it", int'(in_it), int'(e.rem != 3'd0));
        chk(e.name, "it_last", int'(it_last), int'(e.rem == 3'd1));
        chk(e.name, "it_remaining", int'(it_remaining), int'(e.rem));
        chk(e.name, "cond_out", int'(cond_out), int'(e.cond));
        chk(e.name, "exec_pass", int'(exec_pass), int'(e.pass));
        chk(e.name, "it_fault", int'(it_fault), int'(e.fault));
      end
    end
  end

  task automatic push(string nm, logic [7:0] e_it, logic [2:0] e_rem, logic [3:0] e_cond,
                      logic e_pass, logic e_fault);
    exp_t e;
    e.name = nm; e.it = e_it; e.rem = e_rem; e.cond = e_cond; e.pass = e_pass;
    e.fault = e_fault;
    q.push_back(e);
  endtask

  task automatic step(string nm, logic ld, logic [3:0] fc, logic [3:0] mk, logic a, logic st,
                      logic fl, logic rv, logic [7:0] rs, logic [3:0] ic, logic [3:0] nzcv,
                      logic [7:0] e_it, logic [2:0] e_rem, logic [3:0] e_cond, logic e_pass,
                      logic e_fault);
    it_load = ld; it_firstcond = fc; it_mask = mk; adv = a; stall = st; flush = fl;
    restore_valid = rv; restore_itstate = rs; instr_cond = ic;
    {N, Z, C, V} = nzcv;
    @(posedge clk);
    #1;
    push(nm, e_it, e_rem, e_cond, e_pass, e_fault);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    it_load = 1'b0; adv = 1'b0; stall = 1'b0; flush = 1'b0; restore_valid = 1'b0;
    instr_cond = 4'b1110;
    {N, Z, C, V} = 4'b0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic f;
    rst_n = 1'b0;
    #1;
    push("reset", 8'h00, 3'd0, 4'hE, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    //   name           ld fc    mk    a  st fl rv rs     ic    nzcv     it     rem  cond pass flt
    step("ite_load",    1, 4'h0, 4'hC, 0, 0, 0, 0, 8'h00, 4'hE, 4'b0100, 8'h0C, 2, 4'h0, 1, 0);
    step("ite_adv1",    0, 4'h0, 4'h0, 1, 0, 0, 0, 8'h00, 4'hE, 4'b0100, 8'h18, 1, 4'h1, 0, 0);
    step("ite_adv2",    0, 4'h0, 4'h0, 1, 0, 0, 0, 8'h00, 4'hE, 4'b0100, 8'h00, 0, 4'hE, 1, 0);
    step("gt_load",     1, 4'hC, 4'h1, 0, 0, 0, 0, 8'h00, 4'hE, 4'b1001, 8'hC1, 4, 4'hC, 1, 0);
    step("gt_adv1",     0, 4'h0, 4'h0, 1, 0, 0, 0, 8'h00, 4'hE, 4'b1001, 8'hC2, 3, 4'hC, 1, 0);
    step("gt_adv2",     0, 4'h0, 4'h0, 1, 0, 0, 0, 8'h00, 4'hE, 4'b1001, 8'hC4, 2, 4'hC, 1, 0);
    step("gt_adv3",     0, 4'h0, 4'h0, 1, 0, 0, 0, 8'h00, 4'hE, 4'b1001, 8'hC8, 1, 4'hC, 1, 0);
    step("gt_adv4",     0, 4'h0, 4'h0, 1, 0, 0, 0, 8'h00, 4'hE, 4'b1001, 8'h00, 0, 4'hE, 1, 0);
    step("stall_load",  1, 4'h0, 4'hC, 0, 0, 0, 0, 8'h00, 4'hE, 4'b0000, 8'h0C, 2, 4'h0, 0, 0);
    step("stall_adv",   0, 4'h0, 4'h0, 1, 0, 0, 0, 8'h00, 4'hE, 4'b0000, 8'h18, 1, 4'h1, 1, 0);
    for (int i = 0; i < 3; i++)
      step("stall_hold", 0, 4'h0, 4'h0, 1, 1, 0, 0, 8'h00, 4'hE, 4'b0000, 8'h18, 1, 4'h1, 1, 0);
    step("stall_rel",   0, 4'h0, 4'h0, 1, 0, 0, 0, 8'h00, 4'hE, 4'b0000, 8'h00, 0, 4'hE, 1, 0);
    step("flush_ld",    1, 4'h3, 4'h8, 0, 0, 1, 0, 8'h00, 4'hE, 4'b0000, 8'h00, 0, 4'hE, 1, 0);
    step("rest_stall",  0, 4'h0, 4'h0, 0, 1, 0, 1, 8'hA4, 4'hE, 4'b0000, 8'hA4, 2, 4'hA, 1, 0);
    step("rest_flush",  0, 4'h0, 4'h0, 0, 0, 1, 1, 8'h5C, 4'hE, 4'b0000, 8'h5C, 2, 4'h5, 1, 0);
    step("flush",       0, 4'h0, 4'h0, 0, 0, 1, 0, 8'h00, 4'hE, 4'b0000, 8'h00, 0, 4'hE, 1, 0);
    step("nop_hint",    1, 4'h5, 4'h0, 0, 0, 0, 0, 8'h00, 4'h3, 4'b0010, 8'h00, 0, 4'h3, 0, 0);

    f = FaultEn;
    step("nv_load", 1, 4'hF, 4'h8, 0, 0, 0, 0, 8'h00, 4'hE, 4'b0000,
         f ? 8'h00 : 8'hF8, f ? 3'd0 : 3'd1, f ? 4'hE : 4'hF, f, f);
    step("nv_adv", 0, 4'h0, 4'h0, 1, 0, 0, 0, 8'h00, 4'hE, 4'b0000, 8'h00, 0, 4'hE, 1, f);
    step("ld_free", 1, 4'h1, 4'h8, 0, 0, 0, 0, 8'h00, 4'hE, 4'b0000, 8'h18, 1, 4'h1, 1, f);
    step("ld_in_blk", 1, 4'h0, 4'h4, 0, 0, 0, 0, 8'h00, 4'hE, 4'b0000,
         f ? 8'h18 : 8'h04, f ? 3'd1 : 3'd2, f ? 4'h1 : 4'h0, f, f);
    step("rest_clr",  0, 4'h0, 4'h0, 0, 0, 0, 1, 8'h00, 4'hE, 4'b0000, 8'h00, 0, 4'hE, 1, 0);
    step("ld_and_adv", 1, 4'h0, 4'hC, 1, 0, 0, 0, 8'h00, 4'hE, 4'b0000, 8'h0C, 2, 4'h0, 0, 0);
    step("nop_mid",   1, 4'h7, 4'h0, 0, 0, 0, 0, 8'h00, 4'hE, 4'b0000, 8'h0C, 2, 4'h0, 0, 0);

    // Reset pulse between edges must clear state without waiting for a clock.
    idle();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    push("async_rst", 8'h00, 3'd0, 4'hE, 1'b1, 1'b0);
    @(negedge clk);
    #1;

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending expected=0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/it_block_ctrl.md
Name: it_block_ctrl

Overview:
- IT-block sequencer for the 5-stage ARMv8-M pipeline; sits in decode, alongside the conditional engine (`cond`).
- Holds the architectural ITSTATE register.
- Advances ITSTATE once per instruction leaving decode inside an IT block.
- Selects the condition code fed to `cond` and reports whether the current instruction executes.

Parameters:
ITW, 8, ITSTATE width ({cond[3:0], mask[3:0]}); fixed at 8, exposed for lint only
RESTORE_EN_DEFAULT, 1, 1 = restore port honoured; 0 = restore_valid ignored

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
it_load  in  1  IT instruction leaving decode this cycle
it_firstcond  in  4  IT instruction bits [7:4]
it_mask  in  4  IT instruction bits [3:0]
adv  in  1  a non-IT instruction leaves decode this cycle
stall  in  1  decode stalled; blocks load and adv
flush  in  1  pipeline flush (branch taken / exception entry)
restore_valid  in  1  exception return: reload ITSTATE
restore_itstate  in  8  saved ITSTATE value
instr_cond  in  4  condition field of a conditional branch (1110 for unconditional instructions)
N, Z, C, V  in  1 each  current flags (already forwarded)
itstate  out  8  registered ITSTATE
in_it  out  1  itstate[3:0] != 0
it_last  out  1  itstate[3:0] == 4'b1000
it_remaining  out  3  instructions left in block (0..4)
cond_out  out  4  condition presented to `cond`
exec_pass  out  1  `pass` from the internal `cond` instance
it_fault  out  1  sticky illegal-IT flag (macro only; otherwise tied 0)

Behaviour:
- Reset (async, rst_n=0): itstate=8'h00, it_fault=0. Derived outputs follow: in_it=0, it_last=0, it_remaining=0, cond_out=instr_cond.
- Single register update at posedge clk. Priority: restore_valid > flush > stall > it_load > adv.
  - restore_valid=1: itstate <= restore_itstate. Applies even if stall=1.
  - flush=1: itstate <= 0.
  - stall=1: hold.
  - it_load=1 and it_mask != 0: itstate <= {it_firstcond, it_mask}. Latency 1; the next instruction sees the new state.
  - it_load with it_mask==0: treated as a NOP hint; itstate unchanged.
  - adv=1 and in_it:
    - if itstate[2:0]==000: itstate <= 0 (block ends).
    - else: itstate[4:0] <= itstate[4:0]<<1, itstate[7:5] held.
  - adv=1 and !in_it: hold.
  - it_load and adv together: it_load wins; the IT instruction itself is not counted.
- Combinational outputs:
  - cond_out = in_it ? itstate[7:4] : instr_cond.
  - exec_pass = cond(cond_out, N, Z, C, V).
  - it_remaining = 4 - (index of lowest set bit of itstate[3:0]); 0 when !in_it. Examples: mask x1000 -> 1, xxx1 -> 4.
- A branch inside an IT block must be it_last; enforcement belongs to decode, not this block.
- Reset asserted mid-block clears the state immediately; no partial advance.
- No internal counter overflow is possible: the shift terminates within 4 advances.

Optional Feature:
Macro: IT_BLOCK_FAULT_EN
- Defined:
  - it_load while in_it and !flush, or it_load with it_firstcond==4'b1111: load ignored, it_fault <= 1.
  - it_fault stays set until reset or restore_valid.
  - The illegal load does not advance the current block.
- Undefined:
  - it_fault tied 0.
  - it_load while in_it overwrites itstate (normal load rule).
  - firstcond 1111 is loaded as-is; exec_pass is then 0 per `cond` NV.

Test Plan:
- ITE EQ: load firstcond=0000, mask=1100. Expect itstate=8'h0C, cond_out=0000, it_remaining=2. After adv: itstate=8'h18, cond_out=0001, it_last=1. After adv: itstate=0, in_it=0.
- ITTTT GT: load firstcond=1100, mask=0001 with Z=0, N=V=1. Expect exec_pass=1 for 4 advances, it_remaining 4,3,2,1, then in_it=0.
- Stall hold: mid-block itstate=8'h18 with stall=1 and adv=1 for 3 cycles. itstate stays 8'h18. Release stall -> 0.
- Flush vs load: flush=1 and it_load=1 (mask=1000) same cycle. itstate=0 next cycle. restore_valid=1 with 8'hA4 and stall=1 -> itstate=8'hA4.
- Out of block: instr_cond=0011, C=1. Expect cond_out=0011, exec_pass=0. it_load with mask=0000 leaves itstate=0.
- IT_BLOCK_FAULT_EN: load during an active block. itstate unchanged, it_fault=1 sticky. rst_n pulse low mid-cycle clears itstate and it_fault asynchronously.
